// File: rtl/full_st1_sched_if.sv
// Handshake and bus bundle between the stage sequencer and its requesters,
// datapath and tap memory.
interface full_st1_sched_if #(
  parameter int AW = 3
);
  // Requests are level-held until their grant pulse. An issue transfers on
  // any rising edge where st_vld && st_rdy; otherwise the issue holds.
  logic          fwd_req;
  logic          bwd_req;
  logic          upd_en;
  logic          st_rdy;
  logic          fwd_gnt;
  logic          bwd_gnt;
  logic          st_vld;
  logic          first;
  logic          last;
  logic          stage_error_mode;
  logic          stage_error_first;
  logic [AW-1:0] row_addr;
  logic          tap_wr_en;
  logic [AW-1:0] tap_wr_addr;
  logic          busy;
  logic          done;

  modport master (
    input  fwd_req, bwd_req, upd_en, st_rdy,
    output fwd_gnt, bwd_gnt, st_vld, first, last, stage_error_mode,
           stage_error_first, row_addr, tap_wr_en, tap_wr_addr, busy, done
  );

  modport slave (
    output fwd_req, bwd_req, upd_en, st_rdy,
    input  fwd_gnt, bwd_gnt, st_vld, first, last, stage_error_mode,
           stage_error_first, row_addr, tap_wr_en, tap_wr_addr, busy, done
  );
endinterface

// File: rtl/full_st1_sched.sv
// Sequencer/arbiter sharing one tap-row datapath between forward, backward
// and tap-update passes, with a LAT-deep tap write-back strobe pipe.
module full_st1_sched #(
  parameter int N_IN = 8,
  parameter int LAT  = 4,
  parameter int AW   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  full_st1_sched_if.master        bus,
  output logic [2:0]              state_dbg
);

  localparam int DW = $clog2(LAT + 1);
  localparam logic [AW-1:0] LAST_ROW   = AW'(N_IN - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FWD   = 3'd1,
    S_BWD   = 3'd2,
    S_UPD   = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, row_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          last_bwd_q, last_bwd_d;
  logic          fwd_gnt_q, fwd_gnt_d;
  logic          bwd_gnt_q, bwd_gnt_d;
  logic          st_vld_q, st_vld_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          mode_q, mode_d;
  logic          efirst_q, efirst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          wb_vld_q  [LAT];
  logic          wb_vld_d  [LAT];
  logic [AW-1:0] wb_addr_q [LAT];
  logic [AW-1:0] wb_addr_d [LAT];

  logic accept;
  logic upd_accept;
  logic active_d;

  assign accept     = st_vld_q && bus.st_rdy;
  assign upd_accept = accept && (state_q == S_UPD);

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    drain_d    = drain_q;
    last_bwd_d = last_bwd_q;
    fwd_gnt_d  = 1'b0;
    bwd_gnt_d  = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Round-robin: with both requests pending, the pass type that did
        // not win last time goes first.
        if (bus.fwd_req && (!bus.bwd_req || last_bwd_q)) begin
          state_d    = S_FWD;
          fwd_gnt_d  = 1'b1;
          last_bwd_d = 1'b0;
        end else if (bus.bwd_req) begin
          state_d    = S_BWD;
          bwd_gnt_d  = 1'b1;
          last_bwd_d = 1'b1;
        end
      end
      S_FWD, S_BWD, S_UPD: begin
        if (accept) begin
          if (row_q == LAST_ROW) begin
            row_d = '0;
            if (state_q == S_BWD && bus.upd_en) begin
              state_d = S_UPD;
            end else if (LAT == 1) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = S_DRAIN;
              drain_d = DRAIN_INIT;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == DW'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue qualifiers follow the next row so they hold while stalled.
    active_d = (state_d == S_FWD) || (state_d == S_BWD) || (state_d == S_UPD);
    st_vld_d = active_d;
    first_d  = active_d && (row_d == '0);
    last_d   = active_d && (row_d == LAST_ROW);
    mode_d   = (state_d == S_BWD) || (state_d == S_UPD);
    efirst_d = (state_d == S_BWD) && (row_d == '0);
    busy_d   = (state_d != S_IDLE);
  end

  // The write-back pipe shifts every cycle regardless of state or stalls.
  always_comb begin
    wb_vld_d[0]  = upd_accept;
    wb_addr_d[0] = upd_accept ? row_q : '0;
    for (int i = 1; i < LAT; i++) begin
      wb_vld_d[i]  = wb_vld_q[i-1];
      wb_addr_d[i] = wb_addr_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      drain_q    <= '0;
      last_bwd_q <= 1'b1;
      fwd_gnt_q  <= 1'b0;
      bwd_gnt_q  <= 1'b0;
      st_vld_q   <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      mode_q     <= 1'b0;
      efirst_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < LAT; i++) begin
        wb_vld_q[i]  <= 1'b0;
        wb_addr_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      drain_q    <= drain_d;
      last_bwd_q <= last_bwd_d;
      fwd_gnt_q  <= fwd_gnt_d;
      bwd_gnt_q  <= bwd_gnt_d;
      st_vld_q   <= st_vld_d;
      first_q    <= first_d;
      last_q     <= last_d;
      mode_q     <= mode_d;
      efirst_q   <= efirst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      for (int i = 0; i < LAT; i++) begin
        wb_vld_q[i]  <= wb_vld_d[i];
        wb_addr_q[i] <= wb_addr_d[i];
      end
    end
  end

  assign bus.fwd_gnt           = fwd_gnt_q;
  assign bus.bwd_gnt           = bwd_gnt_q;
  assign bus.st_vld            = st_vld_q;
  assign bus.first             = first_q;
  assign bus.last              = last_q;
  assign bus.stage_error_mode  = mode_q;
  assign bus.stage_error_first = efirst_q;
  assign bus.row_addr          = row_q;
  assign bus.tap_wr_en         = wb_vld_q[LAT-1];
  assign bus.tap_wr_addr       = wb_addr_q[LAT-1];
  assign bus.busy              = busy_q;
  assign bus.done              = done_q;
  assign state_dbg             = state_q;

endmodule

// File: tb/tb_full_st1_sched.sv
// Bench for full_st1_sched: expected per-cycle output traces are built from
// the pass timing rules and compared cycle by cycle through a queue.
module tb_full_st1_sched;

  localparam int N_IN = 8;
  localparam int LAT  = 4;
  localparam int AW   = 3;

  typedef struct packed {
    logic          fwd_gnt;
    logic          bwd_gnt;
    logic          st_vld;
    logic          first;
    logic          last;
    logic          mode;
    logic          efirst;
    logic [AW-1:0] row;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
  } out_t;

  localparam int W = $bits(out_t);

  typedef struct {
    bit    is_bwd;
    bit    upd;
    int    stall_at;
    int    stall_len;
    int    exp_done;
    string name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  full_st1_sched_if #(.AW(AW)) bus ();

  full_st1_sched #(.N_IN(N_IN), .LAT(LAT), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  out_t         tl [0:63];
  vec_t         vecs [7];

  function automatic out_t sample_out();
    out_t s;
    s = {bus.fwd_gnt, bus.bwd_gnt, bus.st_vld, bus.first, bus.last,
         bus.stage_error_mode, bus.stage_error_first, bus.row_addr,
         bus.tap_wr_en, bus.tap_wr_addr, bus.busy, bus.done};
    return s;
  endfunction

  function automatic logic rdy_at(input int c, input int sa, input int sl);
    return !(sa >= 0 && c >= sa && c < sa + sl);
  endfunction

  task automatic check(input string name, input int c);
    out_t act;
    out_t expv;
    act = sample_out();
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s cycle %0d: no expected entry, got %h", name, c, act);
      return;
    end
    expv = exp_q.pop_front();
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h required %h", name, c, act, expv);
    end
  endtask

  task automatic check_state(input string name, input logic [2:0] want);
    n_checks++;
    if (state_dbg !== want) begin
      n_fail++;
      $display("FAIL %s state: got %0d required %0d", name, state_dbg, want);
    end
  endtask

  task automatic check_idle(input int n, input string name);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      exp_q.push_back('0);
      check(name, c);
    end
  endtask

  // Expected trace, cycle 0 being the cycle after the edge that samples the
  // request. Issue j spans its stall cycles; an UPD row's write-back lands
  // LAT cycles after its accept edge.
  task automatic build(input bit is_bwd, input bit upd, input int stall_at,
                       input int stall_len, input int d);
    int n, st, ln, r;
    bit is_upd;
    for (int c = 0; c < 64; c++) tl[c] = '0;
    n = (is_bwd && upd) ? 2 * N_IN : N_IN;
    for (int j = 0; j < n; j++) begin
      st     = j + ((stall_at >= 0 && j > stall_at) ? stall_len : 0);
      ln     = (j == stall_at) ? stall_len : 0;
      r      = j % N_IN;
      is_upd = is_bwd && (j >= N_IN);
      for (int c = st; c <= st + ln; c++) begin
        tl[c].st_vld = 1'b1;
        tl[c].row    = AW'(r);
        tl[c].first  = (r == 0);
        tl[c].last   = (r == N_IN - 1);
        tl[c].mode   = is_bwd;
        tl[c].efirst = is_bwd && !is_upd && (r == 0);
      end
      if (is_upd) begin
        tl[st + ln + LAT].wr_en   = 1'b1;
        tl[st + ln + LAT].wr_addr = AW'(r);
      end
    end
    for (int c = 0; c < d; c++) tl[c].busy = 1'b1;
    tl[d].done = 1'b1;
    if (is_bwd) tl[0].bwd_gnt = 1'b1;
    else        tl[0].fwd_gnt = 1'b1;
    for (int c = 0; c <= d; c++) exp_q.push_back(tl[c]);
  endtask

  // Called at a negedge; the following posedge samples the request.
  task automatic run_pass(input bit is_bwd, input bit upd, input int stall_at,
                          input int stall_len, input int d, input bit both,
                          input int stop_at, input string name);
    build(is_bwd, upd, stall_at, stall_len, d);
    if (both) begin
      bus.fwd_req = 1'b1;
      bus.bwd_req = 1'b1;
    end else if (is_bwd) begin
      bus.bwd_req = 1'b1;
    end else begin
      bus.fwd_req = 1'b1;
    end
    bus.upd_en = upd;
    for (int c = 0; c <= d && c <= stop_at; c++) begin
      @(negedge clk);
      check(name, c);
      if (c == 0) begin
        if (is_bwd) bus.bwd_req = 1'b0;
        else        bus.fwd_req = 1'b0;
      end
      bus.st_rdy = rdy_at(c, stall_at, stall_len);
    end
    bus.st_rdy = 1'b1;
  endtask

  initial begin
    int n, sa, sl;
    bit rb, ru;
    reset       = 1'b0;
    bus.fwd_req = 1'b0;
    bus.bwd_req = 1'b0;
    bus.upd_en  = 1'b0;
    bus.st_rdy  = 1'b1;

    repeat (2) @(negedge clk);
    exp_q.push_back('0);
    check("reset_outputs", 0);
    check_state("reset", 3'd0);
    reset = 1'b1;
    check_idle(2, "idle_after_reset");

    // Simultaneous requests: FWD first, then BWD, then FWD again.
    run_pass(1'b0, 1'b0, -1, 0, 11, 1'b1, 1000, "both_fwd_first");
    run_pass(1'b1, 1'b0, -1, 0, 11, 1'b0, 1000, "both_then_bwd");
    check_idle(2, "idle_a");
    run_pass(1'b0, 1'b1, -1, 0, 11, 1'b1, 1000, "both_alt_fwd");
    run_pass(1'b1, 1'b1, -1, 0, 19, 1'b0, 1000, "pending_bwd_upd");
    check_idle(1, "idle_b");

    vecs[0] = '{1'b0, 1'b0, -1, 0, 11, "fwd_plain"};
    vecs[1] = '{1'b1, 1'b1, -1, 0, 19, "bwd_upd"};
    vecs[2] = '{1'b1, 1'b1, 12, 3, 22, "upd_stall_row4"};
    vecs[3] = '{1'b1, 1'b0, -1, 0, 11, "bwd_no_upd"};
    vecs[4] = '{1'b0, 1'b0, 0, 2, 13, "fwd_stall_row0"};
    vecs[5] = '{1'b0, 1'b0, 7, 1, 12, "fwd_stall_row7"};
    rb = 1'($urandom_range(0, 1));
    ru = 1'($urandom_range(0, 1));
    n  = (rb && ru) ? 2 * N_IN : N_IN;
    sa = $urandom_range(0, n - 1);
    sl = $urandom_range(1, 4);
    vecs[6] = '{rb, ru, sa, sl, n - 1 + sl + LAT, "random_stall"};

    for (int i = 0; i < 7; i++) begin
      run_pass(vecs[i].is_bwd, vecs[i].upd, vecs[i].stall_at,
               vecs[i].stall_len, vecs[i].exp_done, 1'b0, 1000, vecs[i].name);
      check_idle(1, "idle_table");
    end

    // Reset during UPD row 5 with write-backs in flight.
    run_pass(1'b1, 1'b1, -1, 0, 19, 1'b0, 13, "upd_before_reset");
    exp_q.delete();
    reset = 1'b0;
    #1;
    exp_q.push_back('0);
    check("reset_mid_upd", 0);
    check_state("reset_mid_upd", 3'd0);
    check_idle(2, "in_reset");
    reset = 1'b1;
    check_idle(6, "after_reset_no_wb");
    run_pass(1'b1, 1'b0, -1, 0, 11, 1'b0, 1000, "bwd_after_reset");
    check_idle(2, "idle_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_st1_sched.md
# full_st1_sched

Sequencer and arbiter for one fully-connected stage. It shares the single tap-row datapath between the forward (data) pass and the backward (error) pass. After each backward pass it runs a tap-update pass. It generates row addresses, the first/last/mode qualifiers, and delayed tap write-back strobes. It sits between the stage's input FIFOs/control and the MAC datapath plus tap/data memories.

## Interface
Parameters:
- N_IN, 8: input vector length; one tap row per input.
- LAT, 4: datapath latency, from accepted issue to result/write-back (≥1).
- AW, $clog2(N_IN): row address width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- fwd_req  in  1  forward input vector loaded; held until fwd_gnt.
- bwd_req  in  1  error vector loaded; held until bwd_gnt.
- upd_en  in  1  quasi-static; 1 = run UPD after each BWD.
- st_rdy  in  1  datapath accepts an issue this cycle.
- fwd_gnt  out  1  one-cycle grant pulse.
- bwd_gnt  out  1  one-cycle grant pulse.
- st_vld  out  1  issue valid.
- first  out  1  issue is row 0 (accumulator clear).
- last  out  1  issue is row N_IN-1.
- stage_error_mode  out  1  1 during BWD and UPD issues.
- stage_error_first  out  1  first issue of a BWD pass.
- row_addr  out  AW  tap/data row of current issue.
- tap_wr_en  out  1  tap row write-back strobe (UPD only).
- tap_wr_addr  out  AW  write-back row.
- busy  out  1  state ≠ IDLE.
- done  out  1  one-cycle pulse when a pass and its drain complete.

## Operation
- States: IDLE, FWD, BWD, UPD, DRAIN. All outputs are registered.
- Reset: all outputs are 0, state IDLE, row counter 0, drain counter 0, write-back pipe cleared, last_winner = BWD (so FWD wins first).
- IDLE:
  - Only fwd_req: enter FWD and pulse fwd_gnt.
  - Only bwd_req: enter BWD and pulse bwd_gnt.
  - Both: round-robin; grant the one not equal to last_winner, then update last_winner.
- FWD/BWD/UPD:
  - st_vld=1 and row_addr=row counter.
  - On st_vld&st_rdy the counter increments. When st_rdy=0, st_vld, row_addr, first and last hold.
  - first=(row==0), last=(row==N_IN-1).
  - stage_error_first=first&&state==BWD.
  - After the last row is accepted, the counter wraps to 0.
  - Next state after the last accepted row: BWD → UPD if upd_en, else DRAIN. FWD and UPD → DRAIN.
- BWD→UPD is back-to-back: the UPD row 0 issue occurs on the cycle after the BWD last accept, with no idle cycle.
- Write-back pipe:
  - LAT-deep shift register of {valid, addr}.
  - Loaded with {1,row} on each UPD accept, otherwise {0,x}.
  - tap_wr_en/tap_wr_addr come from its output.
- DRAIN:
  - Counter loads LAT-1 on entry and decrements each cycle.
  - At 0: done=1 for one cycle, state→IDLE, busy=0 in that same cycle.
  - fwd_req/bwd_req present in that cycle are sampled at the next edge.
  - The pipe keeps shifting in every state, so the final UPD write-back appears exactly in the done cycle.
- Requests arriving while busy are not granted until IDLE. Grant pulses never overlap.
- Reset asserted mid-pass: immediate return to reset values. Pending write-backs are discarded (tap_wr_en=0), and no done is produced.
- upd_en changing mid-pass takes effect only at the BWD last accept.

## Timing
- Grant latency: a req high at edge k in IDLE gives gnt, st_vld=1, first=1 and row_addr=0 in the cycle after edge k.
- Throughput: with st_rdy=1, one row per cycle. FWD occupies N_IN issue cycles, then LAT drain cycles.
- Latency: done asserts LAT cycles after the edge that accepted the last row. For FWD starting at edge k with no stall, done is high in the cycle after edge k+N_IN+LAT-1.
- tap_wr_en for UPD row r is high exactly LAT cycles after row r's accept edge.
- Stalls: each st_rdy=0 cycle delays all subsequent issues, write-backs and done by one cycle.
- Turnaround: from done to the next grant is at least 1 cycle.

## Test plan
- Forward only, N_IN=8, LAT=4, st_rdy=1, fwd_req before edge 0:
  - fwd_gnt and first in the cycle after edge 0; row_addr 0..7; last with row 7.
  - done in the cycle after edge 11; tap_wr_en never asserts.
- BWD with upd_en=1:
  - BWD rows 0..7 with stage_error_first only on row 0, then UPD rows 0..7 contiguously.
  - tap_wr_addr 0..7 each 4 cycles after its accept; done in the same cycle as the row-7 write-back.
- fwd_req and bwd_req both high out of reset:
  - FWD granted first, BWD granted after FWD done.
  - A second simultaneous request after that grants FWD again (alternation).
- Backpressure: st_rdy=0 for 3 cycles at row 4 of UPD.
  - row_addr holds at 4 with st_vld=1.
  - Write-backs for rows 4..7 and done all shift by 3 cycles.
- Reset asserted during UPD row 5 with writes pending:
  - All outputs 0 immediately; no further tap_wr_en; no done.
  - After release, a bwd_req is granted normally from row 0.
- upd_en=0 BWD pass: no UPD; done 4 cycles after the row-7 accept; tap_wr_en stays 0.
